fifo_stream_adapter: RTL and testbench

- Downstream consumer of the team's synchronous FIFO (WIDTH 32, DEPTH 16).
- Drains the FIFO through its rd_en/empty_o/data_o interface and presents the words as a valid/ready stream.
- Inserts a last marker every PKT_LEN words and counts completed packets.
- Registered 3-entry output buffer gives full throughput with no combinational path from m_ready_i to fifo_rd_en_o.

---
 rtl/fifo_stream_pkg.sv | 14 +
 rtl/stream_out_buf.sv | 51 +++++
 rtl/fifo_stream_adapter.sv | 100 ++++++++++
 tb/tb_fifo_stream_adapter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream adapter and its output buffer.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        PAD    = 2'd2
    } state_t;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PKT_CNT_W = 16;

endpackage

// File: rtl/stream_out_buf.sv
// Registered BUF_DEPTH-entry shift buffer; entry 0 is always the head word.
module stream_out_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;
    logic [OCC_W-1:0] w_wr_idx;

    assign w_pop    = pop && (r_occ != '0);
    // A simultaneous pop shifts everything down, so the tail slot moves down by one.
    assign w_wr_idx = w_pop ? r_occ - OCC_W'(1) : r_occ;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_occ <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (push && (w_wr_idx < OCC_W'(BUF_DEPTH))) begin
                r_mem[w_wr_idx] <= push_data;
            end
            if (push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!push && w_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign head_data = r_mem[0];
    assign occ       = r_occ;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a synchronous FIFO into a valid/ready stream, marking last every PKT_LEN words.
// Define FIFO_STREAM_ADAPTER_PAD_FLUSH_EN to close stalled partial packets with PAD_WORD.
module fifo_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      PKT_LEN  = 4,
    parameter int unsigned      TIMEOUT  = 8,
    parameter logic [WIDTH-1:0] PAD_WORD = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 fifo_rd_en_o,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    output logic [PKT_CNT_W-1:0] pkt_cnt_o
);

`ifdef FIFO_STREAM_ADAPTER_PAD_FLUSH_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic                 r_inflight;
    logic [CNT_W-1:0]     r_word_cnt;
    logic [PKT_CNT_W-1:0] r_pkt_cnt;
    logic [TMR_W-1:0]     r_timer;

    logic [OCC_W-1:0]     w_occ;
    logic [WIDTH-1:0]     w_head;
    logic [OCC_W:0]       w_fill;
    logic                 w_rd_en;
    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_idle;
    logic                 w_pad_go;

    stream_out_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (r_inflight),
        .push_data(fifo_data_i),
        .pop      (w_xfer && (r_state != PAD)),
        .head_data(w_head),
        .occ      (w_occ)
    );

    // In-flight reads count against buffer space so a stalled sink can never overflow it.
    assign w_fill   = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
    assign w_rd_en  = rst_i && !fifo_empty_i && (w_fill < (OCC_W+1)'(BUF_DEPTH)) && (r_state != PAD);
    assign w_valid  = (w_occ != '0) || (r_state == PAD);
    assign w_xfer   = w_valid && m_ready_i;
    assign w_last   = w_valid && ((r_state == PAD) || (r_word_cnt == CNT_W'(PKT_LEN - 1)));
    assign w_idle   = (r_state == IN_PKT) && (w_occ == '0) && !r_inflight && fifo_empty_i;
    assign w_pad_go = PAD_EN && w_idle && (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_timer    <= '0;
        end else begin
            r_inflight <= w_rd_en;
            r_timer    <= (PAD_EN && w_idle) ? r_timer + TMR_W'(1) : '0;
            if (w_xfer) begin
                if (w_last) begin
                    r_word_cnt <= '0;
                    r_pkt_cnt  <= r_pkt_cnt + PKT_CNT_W'(1);
                    r_state    <= IDLE;
                end else begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                    r_state    <= IN_PKT;
                end
            end else if (w_pad_go) begin
                r_state <= PAD;
            end
        end
    end

    assign fifo_rd_en_o = w_rd_en;
    assign m_valid_o    = w_valid;
    assign m_data_o     = (r_state == PAD) ? PAD_WORD : w_head;
    assign m_last_o     = w_last;
    assign pkt_cnt_o    = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter with a behavioural FIFO on its read side.
module tb_fifo_stream_adapter;

    localparam int unsigned WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             fifo_rd_en_o;
    logic             fifo_empty_i;
    logic [WIDTH-1:0] fifo_data_i = '0;
    logic             m_valid_o;
    logic             m_ready_i = 1'b0;
    logic [WIDTH-1:0] m_data_o;
    logic             m_last_o;
    logic [15:0]      pkt_cnt_o;

    int checks = 0;
    int errors = 0;

    fifo_stream_adapter #(
        .WIDTH   (WIDTH),
        .PKT_LEN (4),
        .TIMEOUT (8),
        .PAD_WORD(32'hDEAD_BEEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Source FIFO: written by the stimulus, read on accepted strobes, data one cycle later.
    logic [WIDTH-1:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk_i) begin
        if (fifo_rd_en_o) begin
            fifo_data_i <= fmem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [31:0] v);
        fmem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; holds ready high and checks n consecutive words.
    task automatic drain(input int n, input logic [31:0] base, input logic [15:0] lmask, input string tag);
        int got = 0;
        m_ready_i = 1'b1;
        for (int c = 0; c < 40 && got < n; c++) begin
            #1;
            if (m_valid_o) begin
                check({tag, " data"}, m_data_o, base + got);
                check({tag, " last"}, {31'd0, m_last_o}, {31'd0, lmask[got]});
                got++;
            end
            @(negedge clk_i);
        end
        check({tag, " count"}, got, n);
    endtask

    typedef struct {
        logic        ready;
        logic        rd_en;
        logic        valid;
        logic [31:0] data;
        logic        last;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int reads;
        int got;
        int idle;
        logic seen;
        logic prev_stall;
        logic [31:0] prev_data;

        // Cycle 0 is the first cycle with reset released.
        vecs = '{
            '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 32'd1, 1'b0},
            '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0},
            '{1'b1, 1'b1, 1'b1, 32'd3, 1'b0},
            '{1'b1, 1'b1, 1'b1, 32'd4, 1'b1},
            '{1'b1, 1'b1, 1'b1, 32'd5, 1'b0},
            '{1'b1, 1'b1, 1'b1, 32'd6, 1'b0},
            '{1'b1, 1'b0, 1'b1, 32'd7, 1'b0},
            '{1'b1, 1'b0, 1'b1, 32'd8, 1'b1},
            '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0}
        };

        // Reset held for two edges with the FIFO already holding words 1..8.
        for (int i = 1; i <= 8; i++) push(i);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
        check("rst valid", {31'd0, m_valid_o}, 32'd0);
        check("rst last", {31'd0, m_last_o}, 32'd0);
        check("rst data", m_data_o, 32'd0);
        check("rst pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 11; i++) begin
            m_ready_i = vecs[i].ready;
            #1;
            check($sformatf("vec%0d rd_en", i), {31'd0, fifo_rd_en_o}, {31'd0, vecs[i].rd_en});
            check($sformatf("vec%0d valid", i), {31'd0, m_valid_o}, {31'd0, vecs[i].valid});
            check($sformatf("vec%0d last", i), {31'd0, m_last_o}, {31'd0, vecs[i].last});
            if (vecs[i].valid) check($sformatf("vec%0d data", i), m_data_o, vecs[i].data);
            @(negedge clk_i);
        end
        check("stream pkt_cnt", {16'd0, pkt_cnt_o}, 32'd2);

        // Random sink readiness over 16 words; a stalled head must not change.
        for (int i = 0; i < 16; i++) push(32'h1000 + i);
        got = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 200 && (c < 100 || got < 16); c++) begin
            m_ready_i = (c < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check("rand hold valid", {31'd0, m_valid_o}, 32'd1);
                check("rand hold data", m_data_o, prev_data);
            end
            if (m_valid_o && m_ready_i) begin
                check("rand data", m_data_o, 32'h1000 + got);
                check("rand last", {31'd0, m_last_o}, {31'd0, (got % 4) == 3});
                got++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data = m_data_o;
            @(negedge clk_i);
        end
        check("rand count", got, 16);
        check("rand pkt_cnt", {16'd0, pkt_cnt_o}, 32'd6);

        // Stalled sink: only three reads may be outstanding.
        for (int i = 0; i < 10; i++) push(100 + i);
        m_ready_i = 1'b0;
        reads = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (fifo_rd_en_o) reads++;
            @(negedge clk_i);
        end
        check("bp reads", reads, 3);
        #1;
        check("bp valid", {31'd0, m_valid_o}, 32'd1);
        check("bp head", m_data_o, 32'd100);
        drain(10, 32'd100, 16'h0088, "bp");
        check("bp pkt_cnt", {16'd0, pkt_cnt_o}, 32'd8);

        // Two words into a packet: a one-cycle reset must restart framing.
        rst_i = 1'b0;
        #1;
        check("midrst rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("midrst valid", {31'd0, m_valid_o}, 32'd0);
        check("midrst pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);
        for (int i = 0; i < 4; i++) push(200 + i);
        drain(4, 32'd200, 16'h0008, "refill");
        check("refill pkt_cnt", {16'd0, pkt_cnt_o}, 32'd1);

        // Partial packet left waiting on an empty FIFO.
        push(300);
        push(301);
        drain(2, 32'd300, 16'h0000, "partial");
        m_ready_i = 1'b0;
        idle = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid_o) begin
                seen = 1'b1;
                break;
            end
            idle++;
            @(negedge clk_i);
        end
`ifdef FIFO_STREAM_ADAPTER_PAD_FLUSH_EN
        check("pad seen", {31'd0, seen}, 32'd1);
        check("pad idle cycles", idle, 8);
        check("pad data", m_data_o, 32'hDEAD_BEEF);
        check("pad last", {31'd0, m_last_o}, 32'd1);
        push(400);
        #1;
        check("pad no read", {31'd0, fifo_rd_en_o}, 32'd0);
        m_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("pad pkt_cnt", {16'd0, pkt_cnt_o}, 32'd2);
        drain(1, 32'd400, 16'h0000, "after pad");
`else
        check("no pad seen", {31'd0, seen}, 32'd0);
        check("no pad idle", idle, 20);
        check("no pad pkt_cnt", {16'd0, pkt_cnt_o}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
